controlador_execucao: RTL and testbench

Execution controller that generates the processor clock `clk` from the board clock `clk0`. It replaces the free-running divider inside the processor top. It sequences run, single-step, halt and run-to-breakpoint modes from the board switches and a step button. It compares the processor PC against a breakpoint address and freezes `clk` high on a match, so the processor sees a complete clock period on every transition.

---
 rtl/execucao_pkg.sv | 33 +++
 rtl/debounce_botao.sv | 58 +++++
 rtl/controlador_execucao.sv | 165 ++++++++++++++++
 tb/tb_controlador_execucao.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/execucao_pkg.sv
// Shared definitions for the execution controller: operating-mode codes,
// FSM state encoding and small decode helpers.
package execucao_pkg;

  // Operating modes selected by the board switches
  localparam logic [1:0] MODO_RUN    = 2'b00;
  localparam logic [1:0] MODO_STEP   = 2'b01;
  localparam logic [1:0] MODO_HALT   = 2'b10;
  localparam logic [1:0] MODO_RUN_BP = 2'b11;

  // Divider counter width: covers DIV_COUNT up to 2^26-1
  localparam int CNT_W    = 26;
  localparam int CICLOS_W = 32;

  // Controller states, 3-bit so they map straight onto the debug LEDs
  typedef enum logic [2:0] {
    ST_PARADO      = 3'd0,
    ST_RODANDO     = 3'd1,
    ST_PASSO_BAIXO = 3'd2,
    ST_BREAK       = 3'd3
  } estado_t;

  // Modes in which the processor clock free-runs
  function automatic logic modo_roda(input logic [1:0] m);
    return (m == MODO_RUN) || (m == MODO_RUN_BP);
  endfunction

  // States in which clk is frozen high
  function automatic logic estado_parado(input estado_t s);
    return (s == ST_PARADO) || (s == ST_BREAK);
  endfunction

endpackage

// File: rtl/debounce_botao.sv
// Step-button conditioner: two-flop synchroniser for the asynchronous,
// active-low button, a stability filter, and a one-cycle pulse on each
// debounced press (1->0 transition). Reset returns every flop to the
// released level so a reset never manufactures a press.
module debounce_botao #(
  parameter int DEB_COUNT = 500000
) (
  input  logic clk0,
  input  logic reset,
  input  logic passo,
  output logic pulso_passo
);

  localparam int DEB_W = (DEB_COUNT < 2) ? 1 : $clog2(DEB_COUNT);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_COUNT - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             nivel_q;
  logic             nivel_d;
  logic             nivel_ant_q;
  logic [DEB_W-1:0] deb_cnt_q;
  logic [DEB_W-1:0] deb_cnt_d;

  // The debounced level follows the synchronised input only after it has
  // differed from it for DEB_COUNT consecutive cycles; any bounce restarts it.
  always_comb begin
    nivel_d   = nivel_q;
    deb_cnt_d = '0;
    if (sync2_q != nivel_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        nivel_d = sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  // Synchroniser, filter state and edge-detect register
  always_ff @(posedge clk0) begin
    if (!reset) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      nivel_q     <= 1'b1;
      nivel_ant_q <= 1'b1;
      deb_cnt_q   <= '0;
    end else begin
      sync1_q     <= passo;
      sync2_q     <= sync1_q;
      nivel_q     <= nivel_d;
      nivel_ant_q <= nivel_q;
      deb_cnt_q   <= deb_cnt_d;
    end
  end

  assign pulso_passo = nivel_ant_q & ~nivel_q;

endmodule

// File: rtl/controlador_execucao.sv
// Execution controller: derives the processor clock clk from clk0 and
// sequences run, single-step, halt and run-to-breakpoint. clk always
// completes whole periods; a freeze only ever happens with clk high.
// Optional build macro CONTADOR_CICLOS_EN adds the 32-bit rising-edge
// counter on ciclos; without it ciclos reads 0 and FSM timing is unchanged.
module controlador_execucao
  import execucao_pkg::*;
#(
  parameter int DIV_COUNT = 25000000,
  parameter int STEP_HALF = 4,
  parameter int DEB_COUNT = 500000,
  parameter int PC_W      = 16
) (
  input  logic            clk0,
  input  logic            reset,
  input  logic [1:0]      modo,
  input  logic            passo,
  input  logic [PC_W-1:0] pc,
  input  logic [PC_W-1:0] bp_addr,
  output logic            clk,
  output logic [2:0]      estado,
  output logic            parado,
  output logic [31:0]     ciclos
);

  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_COUNT - 1);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_HALF - 1);

  estado_t          estado_q;
  estado_t          estado_d;
  logic             clk_q;
  logic             clk_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             supr_bp_q;
  logic             supr_bp_d;
  logic             parado_q;
  logic             pulso_passo;

  debounce_botao #(
    .DEB_COUNT (DEB_COUNT)
  ) u_debounce (
    .clk0        (clk0),
    .reset       (reset),
    .passo       (passo),
    .pulso_passo (pulso_passo)
  );

  // Next-state logic: state, clk level, divider count and the
  // breakpoint-suppress flag for the first high phase after a BREAK resume.
  always_comb begin
    estado_d  = estado_q;
    clk_d     = clk_q;
    cnt_d     = cnt_q;
    supr_bp_d = supr_bp_q;
    case (estado_q)
      ST_PARADO: begin
        clk_d = 1'b1;
        if (modo_roda(modo)) begin
          estado_d  = ST_RODANDO;
          cnt_d     = '0;
          supr_bp_d = 1'b0;
        end else if ((modo == MODO_STEP) && pulso_passo) begin
          estado_d = ST_PASSO_BAIXO;
          clk_d    = 1'b0;
          cnt_d    = '0;
        end
      end
      ST_RODANDO: begin
        if (clk_q && !modo_roda(modo)) begin
          // High phase can be cut short: the processor has already seen the rise
          estado_d = ST_PARADO;
        end else if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (clk_q) begin
            // End of high phase: the cycle clk would fall
            if ((modo == MODO_RUN_BP) && !supr_bp_q && (pc == bp_addr)) begin
              estado_d = ST_BREAK;
            end else begin
              clk_d = 1'b0;
            end
            supr_bp_d = 1'b0;
          end else begin
            // End of low phase: always raise clk, then stop if asked to
            clk_d = 1'b1;
            if (!modo_roda(modo)) begin
              estado_d = ST_PARADO;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_PASSO_BAIXO: begin
        clk_d = 1'b0;
        if (cnt_q == STEP_LAST) begin
          clk_d    = 1'b1;
          cnt_d    = '0;
          estado_d = ST_PARADO;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_BREAK: begin
        clk_d = 1'b1;
        if (pulso_passo) begin
          estado_d = ST_PASSO_BAIXO;
          clk_d    = 1'b0;
          cnt_d    = '0;
        end else if (modo == MODO_RUN) begin
          estado_d  = ST_RODANDO;
          cnt_d     = '0;
          supr_bp_d = 1'b1;
        end else if ((modo == MODO_HALT) || (modo == MODO_STEP)) begin
          estado_d = ST_PARADO;
        end
      end
      default: begin
        estado_d  = ST_PARADO;
        clk_d     = 1'b1;
        cnt_d     = '0;
        supr_bp_d = 1'b0;
      end
    endcase
  end

  // State register; reset forces clk high on the very next clk0 edge
  always_ff @(posedge clk0) begin
    if (!reset) begin
      estado_q  <= ST_PARADO;
      clk_q     <= 1'b1;
      cnt_q     <= '0;
      supr_bp_q <= 1'b0;
      parado_q  <= 1'b1;
    end else begin
      estado_q  <= estado_d;
      clk_q     <= clk_d;
      cnt_q     <= cnt_d;
      supr_bp_q <= supr_bp_d;
      parado_q  <= estado_parado(estado_d);
    end
  end

`ifdef CONTADOR_CICLOS_EN
  logic [CICLOS_W-1:0] ciclos_q;

  // Count clk rising edges; wraps naturally at 2^32
  always_ff @(posedge clk0) begin
    if (!reset) begin
      ciclos_q <= '0;
    end else if (clk_d && !clk_q) begin
      ciclos_q <= ciclos_q + 1'b1;
    end
  end

  assign ciclos = ciclos_q;
`else
  assign ciclos = '0;
`endif

  assign clk    = clk_q;
  assign estado = estado_q;
  assign parado = parado_q;

endmodule

// File: tb/tb_controlador_execucao.sv
// Directed bench for controlador_execucao with small timing parameters.
// Expected low-phase lengths are queued before each stimulus step and
// popped when the bench sees the matching clk rising edge.
module tb_controlador_execucao;

  localparam int DIV  = 4;
  localparam int STEP = 2;
  localparam int DEB  = 3;

  logic        clk0 = 1'b0;
  logic        reset;
  logic [1:0]  modo;
  logic        passo;
  logic [15:0] pc;
  logic [15:0] bp_addr;
  logic        clk;
  logic [2:0]  estado;
  logic        parado;
  logic [31:0] ciclos;

  logic [31:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          rise_stamp = 0;
  int          exp_ciclos = 0;
  logic [15:0] tb_rises = '0;
  logic [15:0] pc_off = '0;

  controlador_execucao #(
    .DIV_COUNT (DIV),
    .STEP_HALF (STEP),
    .DEB_COUNT (DEB),
    .PC_W      (16)
  ) dut (
    .clk0    (clk0),
    .reset   (reset),
    .modo    (modo),
    .passo   (passo),
    .pc      (pc),
    .bp_addr (bp_addr),
    .clk     (clk),
    .estado  (estado),
    .parado  (parado),
    .ciclos  (ciclos)
  );

  // ---------------- clock / pc model ----------------
  always #5 clk0 = ~clk0;

  // The bench plays the processor: PC advances on every clk rise
  always @(posedge clk) tb_rises <= tb_rises + 16'd1;
  assign pc = tb_rises - pc_off;

  // ---------------- driver / checker tasks ----------------
  task automatic tick();
    @(negedge clk0);
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    errors++;
    $error("FAIL %s: timed out waiting for clk", tag);
  endtask

  function automatic logic [31:0] exp_cic();
`ifdef CONTADOR_CICLOS_EN
    return exp_ciclos;
`else
    return 32'd0;
`endif
  endfunction

  // Waits for the next clk rise; compares low-phase length against the queue
  task automatic wait_rise(input string tag);
    int          lowcnt;
    bit          seen_low;
    bit          done;
    logic [31:0] exp;
    lowcnt   = 0;
    seen_low = 0;
    done     = 0;
    if (clk === 1'b0) begin
      lowcnt   = 1;
      seen_low = 1;
    end
    for (int n = 0; n < 60 && !done; n++) begin
      tick();
      if (clk === 1'b0) begin
        lowcnt++;
        seen_low = 1;
      end else if (seen_low) begin
        done = 1;
      end
    end
    exp = exp_q.pop_front();
    if (!done) begin
      timeout(tag);
    end else begin
      rise_stamp = cyc;
      exp_ciclos++;
      check(tag, lowcnt, exp);
    end
  endtask

  task automatic wait_fall(input string tag);
    bit done;
    done = 0;
    for (int n = 0; n < 60 && !done; n++) begin
      tick();
      if (clk === 1'b0) done = 1;
    end
    if (!done) timeout(tag);
  endtask

  // clk must stay high for the whole window
  task automatic quiet(input int n_ticks, input string tag);
    int lows;
    lows = 0;
    for (int n = 0; n < n_ticks; n++) begin
      tick();
      if (clk !== 1'b1) lows++;
    end
    check(tag, lows, 0);
  endtask

  task automatic press(input int n_ticks);
    passo = 1'b0;
    for (int n = 0; n < n_ticks; n++) tick();
    passo = 1'b1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int s1;
    int s2;
    reset   = 1'b0;
    modo    = 2'b10;
    passo   = 1'b1;
    bp_addr = 16'hFFFF;
    repeat (3) tick();
    check("rst_clk", {31'd0, clk}, 1);
    check("rst_estado", {29'd0, estado}, 0);
    check("rst_parado", {31'd0, parado}, 1);
    check("rst_ciclos", ciclos, 0);
    reset = 1'b1;
    tick();

    // 1: free run, period 8
    modo = 2'b00;
    repeat (3) exp_q.push_back(32'd4);
    wait_rise("run_low1");
    s1 = rise_stamp;
    wait_rise("run_low2");
    s2 = rise_stamp;
    check("run_period1", s2 - s1, 8);
    wait_rise("run_low3");
    check("run_period2", rise_stamp - s2, 8);
    check("run_ciclos", ciclos, exp_cic());
    check("run_parado", {31'd0, parado}, 0);
    check("run_estado", {29'd0, estado}, 1);

    // 2: halt while clk low finishes the period
    wait_fall("halt_fall");
    modo = 2'b10;
    exp_q.push_back(32'd4);
    wait_rise("halt_low");
    check("halt_estado", {29'd0, estado}, 0);
    check("halt_parado", {31'd0, parado}, 1);
    check("halt_ciclos", ciclos, exp_cic());
    quiet(20, "halt_hold");

    // 3: single step; a short glitch must not step
    modo = 2'b01;
    press(2);
    quiet(15, "glitch_nostep");
    press(5);
    wait_fall("step_fall");
    check("step_estado_low", {29'd0, estado}, 2);
    check("step_parado_low", {31'd0, parado}, 0);
    exp_q.push_back(32'd2);
    wait_rise("step_low");
    check("step_estado_end", {29'd0, estado}, 0);
    check("step_ciclos", ciclos, exp_cic());
    quiet(15, "step_single");

    // 4: run to breakpoint at pc 5, then step past it
    bp_addr = 16'd5;
    pc_off  = tb_rises;
    modo    = 2'b11;
    repeat (5) exp_q.push_back(32'd4);
    for (int i = 0; i < 5; i++) wait_rise("bp_low");
    quiet(12, "bp_frozen");
    check("bp_estado", {29'd0, estado}, 3);
    check("bp_parado", {31'd0, parado}, 1);
    check("bp_pc", {16'd0, pc}, 5);
    press(5);
    exp_q.push_back(32'd2);
    wait_rise("bp_step_low");
    modo = 2'b10;
    check("bp_step_pc", {16'd0, pc}, 6);
    check("bp_step_ciclos", ciclos, exp_cic());
    quiet(3, "bp_after_step");
    check("bp_after_estado", {29'd0, estado}, 0);

    // 5: reset in the middle of a step low phase
    modo = 2'b01;
    press(5);
    wait_fall("rst_step_fall");
    reset = 1'b0;
    tick();
    exp_ciclos = 0;
    check("rst_step_clk", {31'd0, clk}, 1);
    check("rst_step_ciclos", ciclos, 0);
    check("rst_step_estado", {29'd0, estado}, 0);
    check("rst_step_parado", {31'd0, parado}, 1);
    reset = 1'b1;
    modo  = 2'b10;
    tick();

    // Counter restarts from zero after reset
    modo = 2'b00;
    exp_q.push_back(32'd4);
    wait_rise("post_rst_low");
    check("post_rst_ciclos", ciclos, exp_cic());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
